// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the x0 register
// constant, and the per-stage enable/flush bundle with its canned settings.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MD_WAIT  = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic md_start;
    } ctrl_t;

    // Field order: pc_en if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en ex_mem_flush mem_wb_flush md_start
    localparam ctrl_t CTRL_RUN      = ctrl_t'(9'b1_1_0_1_0_1_0_0_0);
    localparam ctrl_t CTRL_RESET    = ctrl_t'(9'b0_0_1_0_1_0_1_1_0);
    localparam ctrl_t CTRL_FREEZE   = ctrl_t'(9'b0_0_0_0_0_0_0_1_0);
    localparam ctrl_t CTRL_MD_START = ctrl_t'(9'b0_0_0_0_0_1_1_0_1);
    localparam ctrl_t CTRL_MD_HOLD  = ctrl_t'(9'b0_0_0_0_0_1_1_0_0);

    // Branch squashes the ID instruction, so it takes precedence over load-use.
    function automatic ctrl_t apply_id_hazards(input ctrl_t base, input logic branch,
                                               input logic load_use);
        ctrl_t r;
        r = base;
        if (branch) begin
            r.if_id_flush = 1'b1;
            r.id_ex_flush = 1'b1;
        end else if (load_use) begin
            r.pc_en       = 1'b0;
            r.if_id_en    = 1'b0;
            r.id_ex_flush = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/md_watchdog.sv
// Mul/div wait-time watchdog: counts cycles while a mul/div is outstanding and
// raises a sticky error when MD_TIMEOUT cycles pass without a done.
module md_watchdog #(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    input  logic done,
    output logic expire,
    output logic md_err
);

    localparam int unsigned TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(MD_TIMEOUT - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          md_err_q, md_err_d;

    // Timer saturates at LAST so a memory stall during expiry keeps it asserted.
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (run && (timer_q != LAST)) begin
            timer_d = timer_q + TW'(1);
        end
        expire   = run && !done && (timer_q == LAST);
        md_err_d = md_err_q | expire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q  <= '0;
            md_err_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            md_err_q <= md_err_d;
        end
    end

    assign md_err = md_err_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, branch
// flushes, data-memory waits and mul/div handshake. PERF_CNT_EN adds stall_cnt.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64
`ifdef PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rd_ex,
    input  logic       MemRd_ex,
    input  logic       md_op_ex,
    input  logic       branch_taken_ex,
    input  logic       md_done,
    input  logic       mem_req_me,
    input  logic       dmem_ready,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_en,
    output logic       id_ex_flush,
    output logic       ex_mem_en,
    output logic       ex_mem_flush,
    output logic       mem_wb_flush,
    output logic       md_start,
    output logic       md_err,
    output logic [1:0] state
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    state_e state_q, state_d;
    logic   md_pend_q, md_pend_d;
    ctrl_t  ctrl;
    logic   mem_stall, load_use, done_any;
    logic   wd_clear, wd_run, wd_expire;

    assign mem_stall = mem_req_me & ~dmem_ready;
    assign load_use  = MemRd_ex & (rd_ex != REG_ZERO) & ((rd_ex == rs1_id) | (rd_ex == rs2_id));
    assign done_any  = md_done | md_pend_q;
    assign wd_run    = (state_q == ST_MD_WAIT);

    md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT)) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .run    (wd_run),
        .done   (done_any),
        .expire (wd_expire),
        .md_err (md_err)
    );

    always_comb begin
        ctrl      = CTRL_RUN;
        state_d   = state_q;
        md_pend_d = md_pend_q;
        wd_clear  = 1'b0;
        unique case (state_q)
            // MEM_WAIT release re-runs the RUN rules, so both states share them.
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = ST_MEM_WAIT;
                end else if (md_op_ex) begin
                    ctrl      = CTRL_MD_START;
                    wd_clear  = 1'b1;
                    md_pend_d = 1'b0;
                    state_d   = ST_MD_WAIT;
                end else begin
                    ctrl    = apply_id_hazards(CTRL_RUN, branch_taken_ex, load_use);
                    state_d = ST_RUN;
                end
            end
            ST_MD_WAIT: begin
                if (mem_stall) begin
                    ctrl      = CTRL_FREEZE;
                    md_pend_d = md_pend_q | md_done;
                end else if (done_any || wd_expire) begin
                    ctrl      = apply_id_hazards(CTRL_RUN, branch_taken_ex, load_use);
                    md_pend_d = 1'b0;
                    state_d   = ST_RUN;
                end else begin
                    ctrl = CTRL_MD_HOLD;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            md_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_pend_q <= md_pend_d;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_en     = ctrl.id_ex_en;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign md_start     = ctrl.md_start;
    assign state        = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios then random
// traffic, all checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic       MemRd_ex = 1'b0, md_op_ex = 1'b0, branch_taken_ex = 1'b0;
    logic       md_done = 1'b0, mem_req_me = 1'b0, dmem_ready = 1'b0;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic       ex_mem_en, ex_mem_flush, mem_wb_flush, md_start, md_err;
    logic [1:0] state;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    pipeline_ctrl #(.MD_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .MemRd_ex(MemRd_ex), .md_op_ex(md_op_ex), .branch_taken_ex(branch_taken_ex),
        .md_done(md_done), .mem_req_me(mem_req_me), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .md_start(md_start),
        .md_err(md_err), .state(state)
`ifdef PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Order: pc_en if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en ex_mem_flush mem_wb_flush md_start
    localparam logic [8:0] V_RUN   = 9'b110101000;
    localparam logic [8:0] V_LU    = 9'b000111000;
    localparam logic [8:0] V_BR    = 9'b111111000;
    localparam logic [8:0] V_RST   = 9'b001010110;
    localparam logic [8:0] V_START = 9'b000001101;
    localparam logic [8:0] V_HOLD  = 9'b000001100;
    localparam logic [8:0] V_FRZ   = 9'b000000010;

    logic [8:0] outs;
    assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                   ex_mem_en, ex_mem_flush, mem_wb_flush, md_start};

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode 0=running, 1=waiting on memory, 2=waiting on mul/div.
    int       m_mode, m_cyc;
    bit       m_pend, m_err;
    int unsigned m_stall;

    logic [8:0] last_outs;
    logic [1:0] last_state;
    logic       last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cyc = 0; m_pend = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic idle_inputs();
        rs1_id = '0; rs2_id = '0; rd_ex = '0; MemRd_ex = 0; md_op_ex = 0;
        branch_taken_ex = 0; md_done = 0; mem_req_me = 0; dmem_ready = 0;
    endtask

    // One clock: check outputs at negedge against the model, then advance it.
    task automatic step();
        bit mw, lu, done_now, tout;
        logic [8:0] e;
        int nmode, ncyc;
        bit npend, nerr;
        @(negedge clk);
        mw = mem_req_me && !dmem_ready;
        lu = MemRd_ex && (rd_ex != 0) && (rd_ex == rs1_id || rd_ex == rs2_id);
        nmode = m_mode; ncyc = m_cyc; npend = m_pend; nerr = m_err;
        e = V_RUN;
        if (m_mode != 2) begin
            if (mw) begin
                e = V_FRZ; nmode = 1;
            end else if (md_op_ex) begin
                e = V_START; nmode = 2; ncyc = 0; npend = 0;
            end else begin
                e = branch_taken_ex ? V_BR : (lu ? V_LU : V_RUN);
                nmode = 0;
            end
        end else begin
            done_now = md_done || m_pend;
            tout = !done_now && (m_cyc >= int'(T) - 1);
            if (tout) nerr = 1;
            if (mw) begin
                e = V_FRZ; npend = m_pend || md_done;
                ncyc = (m_cyc + 1 > int'(T) - 1) ? int'(T) - 1 : m_cyc + 1;
            end else if (done_now || tout) begin
                e = branch_taken_ex ? V_BR : (lu ? V_LU : V_RUN);
                nmode = 0; npend = 0;
            end else begin
                e = V_HOLD;
                ncyc = (m_cyc + 1 > int'(T) - 1) ? int'(T) - 1 : m_cyc + 1;
            end
        end
        last_outs = outs; last_state = state; last_err = md_err;
        chk("ctrl", 32'(outs), 32'(e));
        chk("state", 32'(state), 32'(m_mode));
        chk("md_err", 32'(md_err), 32'(m_err));
`ifdef PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        if (!e[8] && m_stall != 32'hFFFF_FFFF) m_stall++;
        m_mode = nmode; m_cyc = ncyc; m_pend = npend; m_err = nerr;
        @(posedge clk); #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_ctrl", 32'(outs), 32'(V_RST));
        chk("rst_state", 32'(state), 0);
        chk("rst_err", 32'(md_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Load-use on rs2, then no match, then rd=x0
        MemRd_ex = 1; rd_ex = 5; rs1_id = 1; rs2_id = 5;
        step(); chk("lu_stall", 32'(last_outs), 32'(V_LU));
        MemRd_ex = 0;
        step(); chk("lu_after", 32'(last_outs), 32'(V_RUN));
        MemRd_ex = 1; rd_ex = 0; rs1_id = 0; rs2_id = 0;
        step(); chk("lu_x0", 32'(last_outs), 32'(V_RUN));

        // Branch beats load-use
        rd_ex = 5; rs2_id = 5; branch_taken_ex = 1;
        step(); chk("br_vs_lu", 32'(last_outs), 32'(V_BR));
        idle_inputs();

        // Mul/div with done 5 cycles after start
        md_op_ex = 1;
        step(); chk("md_start", 32'(last_outs), 32'(V_START));
        for (int i = 1; i <= 5; i++) begin
            md_done = (i == 5);
            step();
            chk("md_state", 32'(last_state), 2);
            chk("md_phase", 32'(last_outs), 32'((i == 5) ? V_RUN : V_HOLD));
        end
        md_op_ex = 0; md_done = 0;
        step(); chk("md_back_run", 32'(last_state), 0);

        // Memory wait for 3 cycles, release on the 4th
        mem_req_me = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("mem_freeze", 32'(last_outs), 32'(V_FRZ));
        end
        dmem_ready = 1;
        step(); chk("mem_release", 32'(last_outs), 32'(V_RUN));
        chk("mem_rel_state", 32'(last_state), 1);
        idle_inputs();

        // Watchdog: no done, release after T cycles in MD_WAIT
        md_op_ex = 1;
        step();
        for (int i = 1; i <= int'(T); i++) begin
            step();
            chk("wd_phase", 32'(last_outs), 32'((i == int'(T)) ? V_RUN : V_HOLD));
        end
        md_op_ex = 0;
        step(); chk("wd_err_set", 32'(last_err), 1);
        step(); step(); chk("wd_err_sticky", 32'(last_err), 1);

        // Async reset while waiting on mul/div
        md_op_ex = 1;
        step(); step();
        md_done = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_err", 32'(md_err), 0);
        chk("arst_ctrl", 32'(outs), 32'(V_RST));
`ifdef PERF_CNT_EN
        chk("arst_cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        MemRd_ex = 1; rd_ex = 3; rs1_id = 3;
        step(); chk("post_rst_lu", 32'(last_outs), 32'(V_LU));
        idle_inputs();
        step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rs1_id          = 5'($urandom_range(0, 3));
            rs2_id          = 5'($urandom_range(0, 3));
            rd_ex           = 5'($urandom_range(0, 3));
            MemRd_ex        = ($urandom_range(0, 2) == 0);
            md_op_ex        = ($urandom_range(0, 6) == 0);
            branch_taken_ex = ($urandom_range(0, 4) == 0);
            md_done         = ($urandom_range(0, 5) == 0);
            mem_req_me      = ($urandom_range(0, 2) == 0);
            dmem_ready      = ($urandom_range(0, 1) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
